// File: rtl/ex_pipe_unit.sv
// Single-issue execute unit: 1-cycle ALU with a valid/ready result register.
// Defining EX_PIPE_MUL_EN adds a DATA_W-cycle signed shift-add multiplier (opcode 8).
module ex_pipe_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] t_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic              use_imm,
    input  logic              update_flag_ov,
    input  logic              update_flag_neg,
    input  logic              update_flag_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              flag_ov,
    output logic              flag_neg,
    output logic              flag_zero,
    output logic              busy
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] sub_rhs;
    logic [SH_W-1:0]   shamt;
    logic [2:0]        upd_in;
    logic              accept;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm_sext
            if (gi < IMM_W) begin : g_bit
                assign imm_ext[gi] = imm[gi];
            end else begin : g_sign
                assign imm_ext[gi] = imm[IMM_W-1];
            end
        end
    endgenerate

    assign src1    = use_imm ? imm_ext : t_data;
    assign sub_rhs = ~src1 + DATA_W'(1);
    assign shamt   = src1[SH_W-1:0];
    assign upd_in  = {update_flag_ov, update_flag_neg, update_flag_zero};

    // Single-cycle ALU; opcode 8 falls to the undefined case here and is
    // intercepted by the multiplier FSM when it is built in.
    logic [DATA_W-1:0] alu_res;
    logic              alu_ov;
    logic              alu_arith;

    always_comb begin
        alu_res   = '0;
        alu_ov    = 1'b0;
        alu_arith = 1'b0;
        case (alu_opcode)
            4'd0: begin
                alu_res   = s_data + src1;
                alu_ov    = (s_data[MSB] == src1[MSB]) && (alu_res[MSB] != s_data[MSB]);
                alu_arith = 1'b1;
            end
            4'd1: begin
                alu_res   = s_data + sub_rhs;
                alu_ov    = (s_data[MSB] == sub_rhs[MSB]) && (alu_res[MSB] != s_data[MSB]);
                alu_arith = 1'b1;
            end
            4'd2: alu_res = s_data & src1;
            4'd3: alu_res = s_data | src1;
            4'd4: alu_res = ~(s_data | src1);
            4'd5: alu_res = s_data << shamt;
            4'd6: alu_res = s_data >> shamt;
            4'd7: alu_res = $signed(s_data) >>> shamt;
            default: ;
        endcase
    end

    logic [DATA_W-1:0] result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic              flag_ov_q, flag_ov_d;
    logic              flag_neg_q, flag_neg_d;
    logic              flag_zero_q, flag_zero_d;

    logic              load;
    logic [DATA_W-1:0] load_res;
    logic              load_ov;
    logic              load_arith;
    logic [2:0]        load_upd;

`ifdef EX_PIPE_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
    state_t              state_q, state_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [SH_W-1:0]     cnt_q, cnt_d;
    logic [2:0]          upd_q, upd_d;
    logic [2*DATA_W-1:0] addend;
    logic [2*DATA_W-1:0] acc_step;
    logic                last_step;
    logic                mul_ov;

    // The multiplier MSB carries negative weight, so the final partial product is subtracted.
    assign last_step = (cnt_q == SH_W'(DATA_W - 1));
    assign addend    = mplier_q[0] ? mcand_q : '0;
    assign acc_step  = last_step ? (acc_q - addend) : (acc_q + addend);
    assign mul_ov    = (acc_step[2*DATA_W-1:DATA_W] != {DATA_W{acc_step[MSB]}});
    assign busy      = (state_q == ST_MUL);
`else
    assign busy      = 1'b0;
`endif

    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        flag_ov_d   = flag_ov_q;
        flag_neg_d  = flag_neg_q;
        flag_zero_d = flag_zero_q;
        load        = 1'b0;
        load_res    = '0;
        load_ov     = 1'b0;
        load_arith  = 1'b0;
        load_upd    = '0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef EX_PIPE_MUL_EN
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        upd_d    = upd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (alu_opcode == 4'd8) begin
                        state_d  = ST_MUL;
                        acc_d    = '0;
                        mcand_d  = {{DATA_W{s_data[MSB]}}, s_data};
                        mplier_d = src1;
                        cnt_d    = '0;
                        upd_d    = upd_in;
                    end else begin
                        load       = 1'b1;
                        load_res   = alu_res;
                        load_ov    = alu_ov;
                        load_arith = alu_arith;
                        load_upd   = upd_in;
                    end
                end
            end
            default: begin
                if (!last_step) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SH_W'(1);
                end else if (!out_valid_q || out_ready) begin
                    // Final step folds into the load so busy lasts exactly DATA_W cycles.
                    load       = 1'b1;
                    load_res   = acc_step[MSB:0];
                    load_ov    = mul_ov;
                    load_arith = 1'b1;
                    load_upd   = upd_q;
                    state_d    = ST_IDLE;
                    acc_d      = '0;
                    cnt_d      = '0;
                end
            end
        endcase
`else
        if (accept) begin
            load       = 1'b1;
            load_res   = alu_res;
            load_ov    = alu_ov;
            load_arith = alu_arith;
            load_upd   = upd_in;
        end
`endif

        if (load) begin
            result_d    = load_res;
            out_valid_d = 1'b1;
            if (load_upd[2]) flag_ov_d   = load_ov;
            if (load_upd[1]) flag_neg_d  = load_arith ? (load_res[MSB] ^ load_ov) : load_res[MSB];
            if (load_upd[0]) flag_zero_d = (load_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            flag_ov_q   <= 1'b0;
            flag_neg_q  <= 1'b0;
            flag_zero_q <= 1'b0;
`ifdef EX_PIPE_MUL_EN
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            upd_q       <= '0;
`endif
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            flag_ov_q   <= flag_ov_d;
            flag_neg_q  <= flag_neg_d;
            flag_zero_q <= flag_zero_d;
`ifdef EX_PIPE_MUL_EN
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            upd_q       <= upd_d;
`endif
        end
    end

    assign alu_result = result_q;
    assign out_valid  = out_valid_q;
    assign flag_ov    = flag_ov_q;
    assign flag_neg   = flag_neg_q;
    assign flag_zero  = flag_zero_q;

endmodule

// File: tb/tb_ex_pipe_unit.sv
// Directed bench for ex_pipe_unit (DATA_W=32, IMM_W=17); MUL scenarios run when EX_PIPE_MUL_EN is defined.
module tb_ex_pipe_unit;
    localparam int DW = 32;
    localparam int IW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_opcode = '0;
    logic [DW-1:0] s_data = '0;
    logic [DW-1:0] t_data = '0;
    logic [IW-1:0] imm = '0;
    logic          use_imm = 1'b0;
    logic          update_flag_ov = 1'b0;
    logic          update_flag_neg = 1'b0;
    logic          update_flag_zero = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] alu_result;
    logic          flag_ov;
    logic          flag_neg;
    logic          flag_zero;
    logic          busy;

    int checks = 0;
    int failures = 0;

    logic          mon_en = 1'b0;
    logic [DW-1:0] mon_q[$];

    always #5 clk = ~clk;

    ex_pipe_unit #(.DATA_W(DW), .IMM_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_opcode(alu_opcode), .s_data(s_data), .t_data(t_data),
        .imm(imm), .use_imm(use_imm),
        .update_flag_ov(update_flag_ov), .update_flag_neg(update_flag_neg),
        .update_flag_zero(update_flag_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result),
        .flag_ov(flag_ov), .flag_neg(flag_neg), .flag_zero(flag_zero),
        .busy(busy)
    );

    // Records every consumed result so loss or duplication shows up as a sequence error.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) mon_q.push_back(alu_result);
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [DW-1:0] s, input logic [DW-1:0] t,
                          input logic ui, input logic [IW-1:0] im, input logic [2:0] upd);
        in_valid   = 1'b1;
        alu_opcode = op;
        s_data     = s;
        t_data     = t;
        use_imm    = ui;
        imm        = im;
        {update_flag_ov, update_flag_neg, update_flag_zero} = upd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({alu_result, out_valid, busy, flag_ov, flag_neg, flag_zero} !== {32'h0, 5'b0}) begin
            failures++;
            $display("FAIL reset_state got res=%h v=%b b=%b f=%b%b%b exp all zero",
                     alu_result, out_valid, busy, flag_ov, flag_neg, flag_zero);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_overflow();
        set_op(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, '0, 3'b111);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_pre got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_result !== 32'h8000_0000 || out_valid !== 1'b1 ||
            {flag_ov, flag_neg, flag_zero} !== 3'b100) begin
            failures++;
            $display("FAIL add_overflow got res=%h v=%b ovnz=%b%b%b exp 80000000 1 100",
                     alu_result, out_valid, flag_ov, flag_neg, flag_zero);
        end
    endtask

    task automatic test_sub_imm_zero();
        set_op(4'd1, 32'd5, 32'hDEAD_BEEF, 1'b1, 17'd5, 3'b111);
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_result !== 32'h0 || {flag_ov, flag_neg, flag_zero} !== 3'b001) begin
            failures++;
            $display("FAIL sub_imm_zero got res=%h ovnz=%b%b%b exp 00000000 001",
                     alu_result, flag_ov, flag_neg, flag_zero);
        end
    endtask

    task automatic test_flag_hold();
        set_op(4'd7, 32'h8000_0000, 32'h0, 1'b1, 17'd4, 3'b101);
        tick();
        checks++;
        if (alu_result !== 32'hF800_0000 || {flag_ov, flag_neg, flag_zero} !== 3'b000) begin
            failures++;
            $display("FAIL sra_neg_hold got res=%h ovnz=%b%b%b exp F8000000 000",
                     alu_result, flag_ov, flag_neg, flag_zero);
        end
        set_op(4'd0, 32'h0, 32'h0, 1'b0, '0, 3'b000);
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_result !== 32'h0 || {flag_ov, flag_neg, flag_zero} !== 3'b000) begin
            failures++;
            $display("FAIL no_update_hold got res=%h ovnz=%b%b%b exp 00000000 000",
                     alu_result, flag_ov, flag_neg, flag_zero);
        end
    endtask

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] s;
        logic [DW-1:0] t;
        logic          ui;
        logic [IW-1:0] im;
        logic [DW-1:0] res;
        logic [2:0]    fl;
    } vec_t;

    task automatic test_alu_vectors();
        vec_t vecs[11];
        vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h1,         1'b0, 17'h0,     32'h0,         3'b001};
        vecs[1]  = '{4'd1,  32'h8000_0000, 32'h1,         1'b0, 17'h0,     32'h7FFF_FFFF, 3'b110};
        vecs[2]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 17'h0,     32'hF000_F000, 3'b010};
        vecs[3]  = '{4'd3,  32'h0000_F000, 32'h0F00_0000, 1'b0, 17'h0,     32'h0F00_F000, 3'b000};
        vecs[4]  = '{4'd4,  32'h0,         32'h0,         1'b0, 17'h0,     32'hFFFF_FFFF, 3'b010};
        vecs[5]  = '{4'd5,  32'h1,         32'h21,        1'b0, 17'h0,     32'h2,         3'b000};
        vecs[6]  = '{4'd6,  32'h8000_0000, 32'd31,        1'b0, 17'h0,     32'h1,         3'b000};
        vecs[7]  = '{4'd0,  32'd10,        32'h0,         1'b1, 17'h1FFFF, 32'd9,         3'b000};
        vecs[8]  = '{4'd12, 32'd5,         32'd5,         1'b0, 17'h0,     32'h0,         3'b001};
        vecs[9]  = '{4'd7,  32'h4000_0000, 32'd4,         1'b0, 17'h0,     32'h0400_0000, 3'b000};
        vecs[10] = '{4'd5,  32'd3,         32'h0,         1'b1, 17'h1FFE2, 32'hC,         3'b000};
        for (int i = 0; i < 11; i++) begin
            set_op(vecs[i].op, vecs[i].s, vecs[i].t, vecs[i].ui, vecs[i].im, 3'b111);
            tick();
            checks++;
            if (alu_result !== vecs[i].res || out_valid !== 1'b1 ||
                {flag_ov, flag_neg, flag_zero} !== vecs[i].fl) begin
                failures++;
                $display("FAIL alu_vec%0d got res=%h v=%b ovnz=%b%b%b exp %h 1 %b", i,
                         alu_result, out_valid, flag_ov, flag_neg, flag_zero, vecs[i].res, vecs[i].fl);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        mon_q.delete();
        mon_en = 1'b1;
        set_op(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, '0, 3'b111);
        tick();
        out_ready = 1'b0;
        set_op(4'd0, 32'd1, 32'd2, 1'b0, '0, 3'b111);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (alu_result !== 32'h8000_0000 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {flag_ov, flag_neg, flag_zero} !== 3'b100) begin
                failures++;
                $display("FAIL stall_hold%0d got res=%h v=%b rdy=%b ovnz=%b%b%b exp 80000000 1 0 100",
                         i, alu_result, out_valid, in_ready, flag_ov, flag_neg, flag_zero);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (alu_result !== 32'd3 || out_valid !== 1'b1 || {flag_ov, flag_neg, flag_zero} !== 3'b000) begin
            failures++;
            $display("FAIL stall_release got res=%h v=%b ovnz=%b%b%b exp 00000003 1 000",
                     alu_result, out_valid, flag_ov, flag_neg, flag_zero);
        end
        set_op(4'd1, 32'd5, 32'd5, 1'b0, '0, 3'b111);
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_result !== 32'h0 || {flag_ov, flag_neg, flag_zero} !== 3'b001) begin
            failures++;
            $display("FAIL stream_third got res=%h ovnz=%b%b%b exp 00000000 001",
                     alu_result, flag_ov, flag_neg, flag_zero);
        end
        tick();
        mon_en = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mon_q.size() != 3) begin
            failures++;
            $display("FAIL stream_count got v=%b consumed=%0d exp 0 3", out_valid, mon_q.size());
        end else begin
            checks++;
            if (mon_q[0] !== 32'h8000_0000 || mon_q[1] !== 32'd3 || mon_q[2] !== 32'h0) begin
                failures++;
                $display("FAIL stream_order got %h %h %h exp 80000000 00000003 00000000",
                         mon_q[0], mon_q[1], mon_q[2]);
            end
        end
    endtask

`ifdef EX_PIPE_MUL_EN
    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] exp_res, input logic [2:0] exp_fl, input string name);
        int busy_cnt;
        int bad;
        busy_cnt = 0;
        bad = 0;
        set_op(4'd8, a, b, 1'b0, '0, 3'b111);
        tick();
        in_valid = 1'b0;
        while (busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (busy_cnt != 32 || bad != 0) begin
            failures++;
            $display("FAIL %s_timing got busy_cycles=%0d ready_or_valid_errs=%0d exp 32 0", name, busy_cnt, bad);
        end
        checks++;
        if (alu_result !== exp_res || out_valid !== 1'b1 || busy !== 1'b0 ||
            {flag_ov, flag_neg, flag_zero} !== exp_fl) begin
            failures++;
            $display("FAIL %s_result got res=%h v=%b b=%b ovnz=%b%b%b exp %h 1 0 %b", name,
                     alu_result, out_valid, busy, flag_ov, flag_neg, flag_zero, exp_res, exp_fl);
        end
    endtask

    task automatic test_mul();
        run_mul(32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 3'b010, "mul_neg");
        run_mul(32'h0001_0000, 32'h0001_0000, 32'h0, 3'b111, "mul_ovf");
        tick();
    endtask
`else
    task automatic test_mul_disabled();
        set_op(4'd8, 32'd3, 32'd7, 1'b0, '0, 3'b111);
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_result !== 32'h0 || out_valid !== 1'b1 || busy !== 1'b0 ||
            {flag_ov, flag_neg, flag_zero} !== 3'b001) begin
            failures++;
            $display("FAIL mul_disabled got res=%h v=%b b=%b ovnz=%b%b%b exp 00000000 1 0 001",
                     alu_result, out_valid, busy, flag_ov, flag_neg, flag_zero);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid_op();
        int late_valid;
        late_valid = 0;
`ifdef EX_PIPE_MUL_EN
        set_op(4'd8, 32'd5, 32'd6, 1'b0, '0, 3'b111);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midop_busy got busy=%b exp 1", busy);
        end
`else
        set_op(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, '0, 3'b111);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midop_valid got out_valid=%b exp 1", out_valid);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_result, out_valid, busy, flag_ov, flag_neg, flag_zero} !== {32'h0, 5'b0}) begin
            failures++;
            $display("FAIL async_reset got res=%h v=%b b=%b f=%b%b%b exp all zero",
                     alu_result, out_valid, busy, flag_ov, flag_neg, flag_zero);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_ready got in_ready=%b busy=%b exp 1 0", in_ready, busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) late_valid++;
            tick();
        end
        checks++;
        if (late_valid != 0) begin
            failures++;
            $display("FAIL no_ghost_result got valid_cycles=%0d exp 0", late_valid);
        end
        set_op(4'd0, 32'd2, 32'd3, 1'b0, '0, 3'b111);
        tick();
        in_valid = 1'b0;
        checks++;
        if (alu_result !== 32'd5 || out_valid !== 1'b1 || {flag_ov, flag_neg, flag_zero} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_add got res=%h v=%b ovnz=%b%b%b exp 00000005 1 000",
                     alu_result, out_valid, flag_ov, flag_neg, flag_zero);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_imm_zero();
        test_flag_hold();
        test_alu_vectors();
        test_back_to_back();
`ifdef EX_PIPE_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_pipe_unit.md
EX_PIPE_UNIT -- requirements
Module: ex_pipe_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width, 8..64, even.
REQ-002 SHALL have parameter IMM_W, default 17: immediate width, sign-extended to DATA_W, IMM_W <= DATA_W.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operation presented.
REQ-006 SHALL have port in_ready, output, 1: unit accepts operation this cycle.
REQ-007 SHALL have port alu_opcode, input, 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9-15 undefined.
REQ-008 SHALL have ports s_data and t_data, input, DATA_W: src0 and src1 register operands.
REQ-009 SHALL have ports imm (input, IMM_W) and use_imm (input, 1): when use_imm=1, src1 = sign-extended imm.
REQ-010 SHALL have ports update_flag_ov, update_flag_neg, update_flag_zero, input, 1 each: per-flag write enables.
REQ-011 SHALL have port out_valid, output, 1: alu_result holds an unconsumed result.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port alu_result, output, DATA_W: registered result.
REQ-014 SHALL have ports flag_ov, flag_neg, flag_zero, output, 1 each: registered flags.
REQ-015 SHALL have port busy, output, 1: multi-cycle operation in progress.

Function
REQ-016 SHALL accept an operation on any rising edge where in_valid=1 and in_ready=1; in_ready = !busy && (!out_valid || out_ready).
REQ-017 SHALL sample all operand, opcode and flag-enable inputs only on acceptance.
REQ-018 SHALL load ops 0-7 and 9-15 into alu_result and set out_valid on the edge after acceptance (1-cycle latency).
REQ-019 SHALL clear out_valid when out_valid=1 and out_ready=1 and no new result loads that edge; simultaneous consume and load keeps out_valid=1 with the new result.
REQ-020 SHALL hold alu_result and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute ADD/SUB modulo 2^DATA_W; ov = signed overflow (operands same sign, result sign differs; SUB uses src0 and ~src1+1).
REQ-022 SHALL use shift amount src1[log2(DATA_W)-1:0] for SLL, SRL and SRA, including immediates.
REQ-023 SHALL produce result 0, ov=0 for undefined opcodes.
REQ-024 SHALL set zero = (result == 0) and neg = result MSB XOR ov for ADD/SUB/MUL, result MSB otherwise; ov=0 for logic and shift ops.
REQ-025 SHALL write each flag only on the edge its result loads and only if its captured update bit was 1; otherwise hold.
REQ-026 SHALL run FSM IDLE -> MUL on accepting opcode 8, stay in MUL for DATA_W cycles (busy=1, in_ready=0), then load result and return to IDLE.
REQ-027 SHALL, for MUL, produce low DATA_W bits of the signed 2*DATA_W product; ov=1 iff the high half is not the sign extension of the low half.
REQ-028 SHALL not start the final MUL load while out_valid=1 and out_ready=0; it waits in MUL with busy=1 until the output register frees.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear alu_result, out_valid, busy, all flags, the FSM to IDLE, and the MUL accumulator/counter.
REQ-030 SHALL abandon any in-flight MUL on reset mid-operation with no result produced; in_ready=1 on the first edge after release.

Configuration
REQ-031 SHALL compile the MUL datapath and FSM state only when macro EX_PIPE_MUL_EN is defined.
REQ-032 SHALL, without EX_PIPE_MUL_EN, treat opcode 8 as undefined (result 0, 1-cycle latency, busy permanently 0).

Verification
REQ-033 SHALL cover: DATA_W=32, ADD 0x7FFFFFFF+1, all update bits=1 -> result 0x80000000, ov=1, neg=0, zero=0, 1-cycle latency.
REQ-034 SHALL cover: SUB 5-5 with use_imm=1, imm=5 -> result 0, zero=1, neg=0, ov=0.
REQ-035 SHALL cover: SRA s_data=0x80000000, use_imm=1, imm=4 -> 0xF8000000; update_flag_neg=0 leaves flag_neg unchanged.
REQ-036 SHALL cover, with EX_PIPE_MUL_EN: MUL -3 x 7 -> 0xFFFFFFEB after 33 cycles, busy=1 for 32, in_ready=0 throughout; 0x10000 x 0x10000 -> 0, ov=1.
REQ-037 SHALL cover: out_ready=0 for 5 cycles with a back-to-back stream -> result and flags held, in_ready=0, no op lost or duplicated after release.
REQ-038 SHALL cover: rst_n low mid-MUL -> all outputs 0 asynchronously, no result after release, next ADD 2+3 -> 5.
